// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch stage and its IF/ID register.
package mips_pkg;

    typedef logic [31:0] word_t;

    localparam word_t       NOP_INSTR        = 32'h0000_0000;
    localparam int unsigned INSTR_BYTES      = 4;
    localparam word_t       RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IFID_LOAD   = 2'd0,
        IFID_HOLD   = 2'd1,
        IFID_BUBBLE = 2'd2
    } ifid_ctrl_e;

endpackage

// File: rtl/mips_fetch_stage_if.sv
// Hazard/redirect inputs, instruction-memory port and IF/ID outputs of the fetch stage.
interface mips_fetch_stage_if;

    logic              stall;
    logic              flush;
    logic              branch_taken;
    mips_pkg::word_t   branch_target;
    logic              jump;
    mips_pkg::word_t   jump_target;
    mips_pkg::word_t   instrn_address;
    mips_pkg::word_t   instrn;
    mips_pkg::word_t   ifid_instr;
    mips_pkg::word_t   ifid_pc_plus4;
    logic              ifid_valid;
    logic              fetch_fault;

    // master is the fetch stage itself; slave is hazard unit, memory and decode.
    modport master (
        input  stall, flush, branch_taken, branch_target, jump, jump_target, instrn,
        output instrn_address, ifid_instr, ifid_pc_plus4, ifid_valid, fetch_fault
    );

    modport slave (
        output stall, flush, branch_taken, branch_target, jump, jump_target, instrn,
        input  instrn_address, ifid_instr, ifid_pc_plus4, ifid_valid, fetch_fault
    );

endinterface

// File: rtl/fetch_ifid_reg.sv
// IF/ID pipeline register: loads a fetched instruction, holds it, or inserts a NOP bubble.
module fetch_ifid_reg
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  ifid_ctrl_e ctrl_i,
    input  word_t      instr_i,
    input  word_t      pc_plus4_i,
    output word_t      instr_o,
    output word_t      pc_plus4_o,
    output logic       valid_o
);

    word_t instr_q, instr_d;
    word_t pc_plus4_q, pc_plus4_d;
    logic  valid_q, valid_d;

    always_comb begin
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        unique case (ctrl_i)
            IFID_LOAD: begin
                instr_d    = instr_i;
                pc_plus4_d = pc_plus4_i;
                valid_d    = 1'b1;
            end
            IFID_BUBBLE: begin
                instr_d    = NOP_INSTR;
                pc_plus4_d = '0;
                valid_d    = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/mips_fetch_stage.sv
// PC register, next-PC selection and sticky fetch-fault tracking feeding the IF/ID register.
module mips_fetch_stage
    import mips_pkg::*;
#(
    parameter word_t       RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned IMEM_BYTES = 32
) (
    input logic                clk,
    input logic                rst_n,
    mips_fetch_stage_if.master bus
);

    localparam word_t LAST_PC = word_t'(IMEM_BYTES - INSTR_BYTES);

    word_t      pc_q, pc_d;
    logic       fault_q, fault_d;
    word_t      pc_plus4;
    word_t      redirect_pc;
    logic       redirect;
    logic       bad_pc;
    ifid_ctrl_e ifid_ctrl;

    always_comb begin
        redirect    = bus.branch_taken | bus.jump;
        redirect_pc = bus.branch_taken ? bus.branch_target : bus.jump_target;
        pc_plus4    = pc_q + word_t'(INSTR_BYTES);
        bad_pc      = (pc_q[1:0] != 2'b00) || (pc_q > LAST_PC);
    end

    // A bad PC freezes on the very edge that raises the fault, so the faulting address stays visible.
    always_comb begin
        pc_d    = pc_plus4;
        fault_d = fault_q;
        if (redirect) begin
            pc_d    = redirect_pc;
            fault_d = 1'b0;
        end else if (bus.stall) begin
            pc_d = pc_q;
        end else if (bad_pc || fault_q) begin
            pc_d    = pc_q;
            fault_d = 1'b1;
        end
    end

    always_comb begin
        if (redirect || bus.flush) begin
            ifid_ctrl = IFID_BUBBLE;
        end else if (bus.stall) begin
            ifid_ctrl = IFID_HOLD;
        end else if (bad_pc || fault_q) begin
            ifid_ctrl = IFID_BUBBLE;
        end else begin
            ifid_ctrl = IFID_LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    fetch_ifid_reg u_ifid_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .ctrl_i     (ifid_ctrl),
        .instr_i    (bus.instrn),
        .pc_plus4_i (pc_plus4),
        .instr_o    (bus.ifid_instr),
        .pc_plus4_o (bus.ifid_pc_plus4),
        .valid_o    (bus.ifid_valid)
    );

    assign bus.instrn_address = pc_q;
    assign bus.fetch_fault    = fault_q;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Self-checking bench for mips_fetch_stage: directed scenarios plus a randomized run against a behavioural model.
module tb_mips_fetch_stage;
    import mips_pkg::*;

    localparam int unsigned IMEM_BYTES = 32;
    localparam int unsigned NUM_WORDS  = IMEM_BYTES / 4;

    logic clk;
    logic rst_n;
    int   numChecks;
    int   numFail;

    word_t mem [NUM_WORDS];

    // Behavioural model of the architecturally visible state.
    word_t mPc;
    word_t mInstr;
    word_t mPc4;
    logic  mValid;
    logic  mFault;

    mips_fetch_stage_if bus ();

    mips_fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (IMEM_BYTES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Instruction memory: combinational read, garbage outside the legal window.
    assign bus.instrn = (bus.instrn_address[1:0] == 2'b00 && bus.instrn_address <= IMEM_BYTES - 4)
                        ? mem[bus.instrn_address[4:2]] : 32'hBAD0_BAD0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [97:0] dutState();
        return {bus.instrn_address, bus.ifid_instr, bus.ifid_pc_plus4, bus.ifid_valid, bus.fetch_fault};
    endfunction

    function automatic logic [97:0] modelState();
        return {mPc, mInstr, mPc4, mValid, mFault};
    endfunction

    task automatic modelReset();
        mPc    = 32'h0;
        mInstr = 32'h0;
        mPc4   = 32'h0;
        mValid = 1'b0;
        mFault = 1'b0;
    endtask

    task automatic clearInputs();
        bus.stall         = 1'b0;
        bus.flush         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'h0;
        bus.jump          = 1'b0;
        bus.jump_target   = 32'h0;
    endtask

    // Advance one clock: model computes its next state from the rules, then the DUT edge happens.
    task automatic tick();
        logic  redir, bad;
        word_t target, nPc, nInstr, nPc4;
        logic  nValid, nFault;
        redir  = bus.branch_taken || bus.jump;
        target = bus.branch_taken ? bus.branch_target : bus.jump_target;
        bad    = (mPc % 4 != 0) || (mPc > IMEM_BYTES - 4);
        nPc = mPc; nFault = mFault;
        nInstr = mInstr; nPc4 = mPc4; nValid = mValid;
        if (redir) begin
            nPc = target; nFault = 1'b0;
        end else if (!bus.stall && (bad || mFault)) begin
            nFault = 1'b1;
        end else if (!bus.stall) begin
            nPc = mPc + 4;
        end
        if (redir || bus.flush || (!bus.stall && (bad || mFault))) begin
            nInstr = 32'h0; nPc4 = 32'h0; nValid = 1'b0;
        end else if (!bus.stall) begin
            nInstr = mem[int'(mPc / 4)]; nPc4 = mPc + 4; nValid = 1'b1;
        end
        @(posedge clk);
        #1;
        mPc = nPc; mFault = nFault; mInstr = nInstr; mPc4 = nPc4; mValid = nValid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clearInputs();
        modelReset();
        #12;
        numChecks++;
        if (dutState() !== {32'h0, 32'h0, 32'h0, 1'b0, 1'b0}) begin
            numFail++;
            $display("[TB] FAIL reset_state: got %h required %h", dutState(), {32'h0, 32'h0, 32'h0, 1'b0, 1'b0});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            tick();
            numChecks++;
            if (dutState() !== modelState()) begin
                numFail++;
                $display("[TB] FAIL seq_%0d: got %h required %h", i, dutState(), modelState());
            end
        end
        numChecks++;
        if (bus.instrn_address !== 32'hC || bus.ifid_instr !== mem[2] || bus.ifid_pc_plus4 !== 32'hC) begin
            numFail++;
            $display("[TB] FAIL seq_const: got addr=%h instr=%h pc4=%h required addr=0000000c instr=%h pc4=0000000c",
                     bus.instrn_address, bus.ifid_instr, bus.ifid_pc_plus4, mem[2]);
        end
    endtask

    task automatic test_stall();
        bus.jump = 1'b1; bus.jump_target = 32'h4;
        tick();
        clearInputs();
        tick();
        bus.stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            numChecks++;
            if (bus.instrn_address !== 32'h8 || bus.ifid_instr !== mem[1] || bus.ifid_pc_plus4 !== 32'h8
                || dutState() !== modelState()) begin
                numFail++;
                $display("[TB] FAIL stall_hold_%0d: got %h required %h", i, dutState(), modelState());
            end
        end
        bus.stall = 1'b0;
        tick();
        numChecks++;
        if (bus.ifid_instr !== mem[2] || bus.ifid_pc_plus4 !== 32'hC || bus.ifid_valid !== 1'b1) begin
            numFail++;
            $display("[TB] FAIL stall_resume: got instr=%h pc4=%h v=%b required instr=%h pc4=0000000c v=1",
                     bus.ifid_instr, bus.ifid_pc_plus4, bus.ifid_valid, mem[2]);
        end
    endtask

    task automatic test_branch_priority();
        bus.branch_taken = 1'b1; bus.branch_target = 32'h10;
        bus.jump = 1'b1; bus.jump_target = 32'h4;
        tick();
        clearInputs();
        numChecks++;
        if (bus.instrn_address !== 32'h10 || bus.ifid_valid !== 1'b0) begin
            numFail++;
            $display("[TB] FAIL branch_over_jump: got addr=%h v=%b required addr=00000010 v=0",
                     bus.instrn_address, bus.ifid_valid);
        end
        tick();
        numChecks++;
        if (bus.ifid_instr !== mem[4] || bus.ifid_pc_plus4 !== 32'h14 || dutState() !== modelState()) begin
            numFail++;
            $display("[TB] FAIL branch_fetch: got %h required %h", dutState(), modelState());
        end
    endtask

    task automatic test_range_fault();
        int budget;
        budget = 0;
        while (bus.instrn_address !== 32'h20 && budget < 20) begin
            tick();
            budget++;
        end
        numChecks++;
        if (budget >= 20) begin
            numFail++;
            $display("[TB] FAIL reach_0x20: got addr=%h required 00000020 within 20 cycles", bus.instrn_address);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            numChecks++;
            if (bus.fetch_fault !== 1'b1 || bus.instrn_address !== 32'h20 || bus.ifid_valid !== 1'b0
                || dutState() !== modelState()) begin
                numFail++;
                $display("[TB] FAIL range_fault_%0d: got %h required %h", i, dutState(), modelState());
            end
        end
        bus.jump = 1'b1; bus.jump_target = 32'h0;
        tick();
        clearInputs();
        numChecks++;
        if (bus.fetch_fault !== 1'b0 || bus.instrn_address !== 32'h0) begin
            numFail++;
            $display("[TB] FAIL fault_clear: got f=%b addr=%h required f=0 addr=00000000",
                     bus.fetch_fault, bus.instrn_address);
        end
        tick();
        numChecks++;
        if (bus.ifid_instr !== mem[0] || bus.ifid_valid !== 1'b1 || dutState() !== modelState()) begin
            numFail++;
            $display("[TB] FAIL fault_resume: got %h required %h", dutState(), modelState());
        end
    endtask

    task automatic test_misaligned();
        bus.jump = 1'b1; bus.jump_target = 32'h6;
        tick();
        clearInputs();
        tick();
        numChecks++;
        if (bus.fetch_fault !== 1'b1 || bus.ifid_valid !== 1'b0 || bus.instrn_address !== 32'h6) begin
            numFail++;
            $display("[TB] FAIL misalign_fault: got f=%b v=%b addr=%h required f=1 v=0 addr=00000006",
                     bus.fetch_fault, bus.ifid_valid, bus.instrn_address);
        end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        numChecks++;
        if (bus.fetch_fault !== 1'b1 || dutState() !== modelState()) begin
            numFail++;
            $display("[TB] FAIL flush_keeps_fault: got %h required %h", dutState(), modelState());
        end
        bus.jump = 1'b1; bus.jump_target = 32'h0;
        tick();
        clearInputs();
        tick();
    endtask

    task automatic test_stall_combos();
        bus.stall = 1'b1; bus.flush = 1'b1;
        tick();
        clearInputs();
        numChecks++;
        if (bus.instrn_address !== 32'h4 || bus.ifid_valid !== 1'b0 || dutState() !== modelState()) begin
            numFail++;
            $display("[TB] FAIL flush_and_stall: got %h required %h", dutState(), modelState());
        end
        bus.stall = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 32'h18;
        tick();
        clearInputs();
        numChecks++;
        if (bus.instrn_address !== 32'h18 || bus.ifid_valid !== 1'b0 || dutState() !== modelState()) begin
            numFail++;
            $display("[TB] FAIL redirect_and_stall: got %h required %h", dutState(), modelState());
        end
    endtask

    task automatic test_async_reset();
        bus.jump = 1'b1; bus.jump_target = 32'h10;
        tick();
        clearInputs();
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        modelReset();
        numChecks++;
        if (bus.instrn_address !== 32'h0 || bus.ifid_valid !== 1'b0 || bus.fetch_fault !== 1'b0
            || dutState() !== modelState()) begin
            numFail++;
            $display("[TB] FAIL async_reset: got %h required %h", dutState(), modelState());
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic word_t randTarget();
        int unsigned r;
        r = $urandom_range(7, 0);
        if (r < 6) return word_t'($urandom_range(NUM_WORDS - 1, 0) * 4);
        if (r == 6) return word_t'($urandom_range(IMEM_BYTES - 1, 0));
        return word_t'($urandom);
    endfunction

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.stall         = ($urandom_range(4, 0) == 0);
            bus.flush         = ($urandom_range(7, 0) == 0);
            bus.branch_taken  = ($urandom_range(9, 0) == 0);
            bus.branch_target = randTarget();
            bus.jump          = ($urandom_range(9, 0) == 0);
            bus.jump_target   = randTarget();
            tick();
            numChecks++;
            if (dutState() !== modelState()) begin
                numFail++;
                $display("[TB] FAIL random_%0d: got %h required %h", i, dutState(), modelState());
            end
        end
        clearInputs();
    endtask

    initial begin
        numChecks = 0;
        numFail   = 0;
        for (int i = 0; i < NUM_WORDS; i++) mem[i] = $urandom;
        test_reset();
        test_sequential();
        test_stall();
        test_branch_priority();
        test_range_fault();
        test_misaligned();
        test_stall_combos();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFail);
        $finish;
    end

endmodule
